// File: rtl/nonblocking_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nonblocking_pkg
//  Brief    : Shared defaults and word type for the non-blocking reference
//             block (counter plus three-stage delay line).
//  Revision : 1.0 - initial release
// ============================================================================
package nonblocking_pkg;

    localparam int WIDTH_DEFAULT   = 32;
    localparam int STEP_DEFAULT    = 1;
    localparam int RST_VAL_DEFAULT = 0;

    typedef logic [WIDTH_DEFAULT-1:0] word_t;

endpackage : nonblocking_pkg
`default_nettype wire

// File: rtl/nb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : nb_stage
//  Brief    : One WIDTH-bit delay register with asynchronous active-low reset
//             to RST_VAL. Chained to build the b -> c -> d delay line.
//  Revision : 1.0 - initial release
// ============================================================================
module nb_stage
    import nonblocking_pkg::*;
#(
    parameter int               WIDTH   = WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(RST_VAL_DEFAULT)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Capture the pre-edge value of the previous stage; reset wins immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : nb_stage
`default_nettype wire

// File: rtl/nonblocking.sv
`default_nettype none
// ============================================================================
//  Module   : nonblocking
//  Brief    : Free-running modulo-2**WIDTH counter (a) feeding a three-stage
//             register delay line (b, c, d = a delayed by 1, 2, 3 clocks).
//             All registers update from pre-edge values on the same edge.
//  Revision : 1.0 - initial release
// ============================================================================
module nonblocking
    import nonblocking_pkg::*;
#(
    parameter int               WIDTH   = WIDTH_DEFAULT,
    parameter int               STEP    = STEP_DEFAULT,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(RST_VAL_DEFAULT)
) (
    input  logic             clock,
    input  logic             reset_n,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d
);

    localparam int               c_depth = 3;
    localparam logic [WIDTH-1:0] c_step  = WIDTH'(STEP);

    logic [WIDTH-1:0] r_a;
    // w_tap[0] is the counter, w_tap[n] is the counter delayed by n clocks.
    logic [WIDTH-1:0] w_tap [0:c_depth];

    // Counter: wraps silently modulo 2**WIDTH, no flag and no saturation.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a <= RST_VAL;
        end else begin
            r_a <= r_a + c_step;
        end
    end

    assign w_tap[0] = r_a;

    // Each stage registers the tap before it, so every stage sees the value
    // held before the edge rather than a same-edge update.
    for (genvar gi = 0; gi < c_depth; gi++) begin : g_stage
        nb_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clock   (clock),
            .reset_n (reset_n),
            .i_d     (w_tap[gi]),
            .o_q     (w_tap[gi+1])
        );
    end

    // Outputs come straight from registers.
    assign a = w_tap[0];
    assign b = w_tap[1];
    assign c = w_tap[2];
    assign d = w_tap[3];

endmodule : nonblocking
`default_nettype wire

// File: tb/tb_nonblocking.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nonblocking
//  Brief    : Directed self-checking bench for nonblocking: reset hold, fill,
//             async mid-run reset, steady state, wrap-around and STEP = 3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nonblocking;

    logic        clock;
    logic        reset_n;
    logic [31:0] a,  b,  c,  d;
    logic [31:0] wa, wb, wc, wd;
    logic [31:0] sa, sb, sc, sd;

    int vectors;
    int miscompares;

    // Default configuration.
    nonblocking u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d)
    );

    // Reset value just below the top of the range, to exercise wrap-around.
    nonblocking #(
        .WIDTH   (32),
        .STEP    (1),
        .RST_VAL (32'hFFFF_FFFE)
    ) u_dut_wrap (
        .clock   (clock),
        .reset_n (reset_n),
        .a       (wa),
        .b       (wb),
        .c       (wc),
        .d       (wd)
    );

    // STEP = 3 variant.
    nonblocking #(
        .WIDTH   (32),
        .STEP    (3),
        .RST_VAL (32'h0)
    ) u_dut_step3 (
        .clock   (clock),
        .reset_n (reset_n),
        .a       (sa),
        .b       (sb),
        .c       (sc),
        .d       (sd)
    );

    // 10-unit period, first rising edge at t = 5.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag,
                        input logic [31:0] oa, input logic [31:0] ob,
                        input logic [31:0] oc, input logic [31:0] od,
                        input logic [31:0] ea, input logic [31:0] eb,
                        input logic [31:0] ec, input logic [31:0] ed);
        chk({tag, ".a"}, oa, ea);
        chk({tag, ".b"}, ob, eb);
        chk({tag, ".c"}, oc, ec);
        chk({tag, ".d"}, od, ed);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [31:0] hist [$];

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;

        // Reset hold: the edge at t = 5 occurs with reset_n low.
        #10;
        chk4("reset_hold", a, b, c, d, 0, 0, 0, 0);
        chk4("reset_hold_wrap", wa, wb, wc, wd,
             32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
        chk4("reset_hold_step3", sa, sb, sc, sd, 0, 0, 0, 0);

        // Release at t = 12, between edges.
        #2;
        reset_n = 1'b1;

        // Fill sequence; the wrap instance crosses the top on the 2nd edge.
        step();
        chk4("fill1", a, b, c, d, 1, 0, 0, 0);
        chk("wrap1.a", wa, 32'hFFFF_FFFF);
        chk("wrap1.b", wb, 32'hFFFF_FFFE);
        step();
        chk4("fill2", a, b, c, d, 2, 1, 0, 0);
        chk("wrap2.a", wa, 32'h0000_0000);
        chk("wrap2.b", wb, 32'hFFFF_FFFF);
        step();
        chk4("fill3", a, b, c, d, 3, 2, 1, 0);
        chk("wrap3.a", wa, 32'h0000_0001);
        chk("wrap3.b", wb, 32'h0000_0000);
        chk("wrap3.c", wc, 32'hFFFF_FFFF);
        chk("wrap3.d", wd, 32'hFFFF_FFFE);
        step();
        chk4("fill4", a, b, c, d, 4, 3, 2, 1);
        chk4("step3", sa, sb, sc, sd, 12, 9, 6, 3);
        step();
        chk4("run5", a, b, c, d, 5, 4, 3, 2);

        // Async reset between edges at t = 63; outputs clear before t = 65.
        #7;
        reset_n = 1'b0;
        #1;
        chk4("async_reset", a, b, c, d, 0, 0, 0, 0);
        chk4("async_reset_step3", sa, sb, sc, sd, 0, 0, 0, 0);
        step();
        chk4("async_reset_held", a, b, c, d, 0, 0, 0, 0);

        // Release between edges and run to steady state.
        #3;
        reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk4($sformatf("restart%0d", k), a, b, c, d,
                 32'(k),
                 32'((k > 1) ? k - 1 : 0),
                 32'((k > 2) ? k - 2 : 0),
                 32'((k > 3) ? k - 3 : 0));
            hist.push_back(a);
            if (hist.size() > 3) begin
                chk($sformatf("d_lag3_%0d", k), d, hist[hist.size()-4]);
            end
        end
        chk4("steady", a, b, c, d, 10, 9, 8, 7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #5000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_nonblocking
`default_nettype wire
